// File: rtl/gate_boy_pkg.sv
// Shared Game Boy CPU types: register/pair selects, flag bit positions and
// the register bank layout used by the register file and its resolver.
package gate_boy_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int FLAG_WIDTH = 8;
    localparam int REG_COUNT  = 8;
    localparam int PAIR_WIDTH = 16;

    // Bit positions of the flags inside F; the low nibble is always zero.
    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5,
        REG_F = 3'd6,
        REG_A = 3'd7
    } reg_sel_t;

    typedef enum logic [1:0] {
        PAIR_BC = 2'd0,
        PAIR_DE = 2'd1,
        PAIR_HL = 2'd2,
        PAIR_AF = 2'd3
    } pair_sel_t;

    typedef logic [REG_COUNT-1:0][DATA_WIDTH-1:0] reg_bank_t;

    // AF is the odd one out: A sits above F in the encoding, so the pair is swapped.
    function automatic reg_sel_t pair_hi(input pair_sel_t p);
        return (p == PAIR_AF) ? REG_A : reg_sel_t'({p, 1'b0});
    endfunction

    function automatic reg_sel_t pair_lo(input pair_sel_t p);
        return (p == PAIR_AF) ? REG_F : reg_sel_t'({p, 1'b1});
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register file port bundle: the CPU/ALU side drives selects and write-back
// (master); the register file answers with operands, pair data and flags (slave).
interface reg_file_if;
    import gate_boy_pkg::*;

    reg_sel_t                rd_a_sel;
    reg_sel_t                rd_b_sel;
    logic [DATA_WIDTH-1:0]   rd_a_data;
    logic [DATA_WIDTH-1:0]   rd_b_data;
    pair_sel_t               rd_pair_sel;
    logic [PAIR_WIDTH-1:0]   rd_pair_data;

    logic                    wr_en;
    reg_sel_t                wr_sel;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    wr_pair_en;
    pair_sel_t               wr_pair_sel;
    logic [PAIR_WIDTH-1:0]   wr_pair_data;

    logic [3:0]              flag_we;
    logic [FLAG_WIDTH-1:0]   flag_in;
    logic [FLAG_WIDTH-1:0]   flags;

    modport master (
        output rd_a_sel, rd_b_sel, rd_pair_sel,
        output wr_en, wr_sel, wr_data,
        output wr_pair_en, wr_pair_sel, wr_pair_data,
        output flag_we, flag_in,
        input  rd_a_data, rd_b_data, rd_pair_data, flags
    );

    modport slave (
        input  rd_a_sel, rd_b_sel, rd_pair_sel,
        input  wr_en, wr_sel, wr_data,
        input  wr_pair_en, wr_pair_sel, wr_pair_data,
        input  flag_we, flag_in,
        output rd_a_data, rd_b_data, rd_pair_data, flags
    );

endinterface

// File: rtl/reg_next.sv
// Per-byte next-value resolver for the register bank: 8-bit write beats pair
// write beats flag update, resolved independently for every byte.
module reg_next
    import gate_boy_pkg::*;
(
    input  reg_bank_t               cur,
    input  logic                    wr_en,
    input  reg_sel_t                wr_sel,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_pair_en,
    input  pair_sel_t               wr_pair_sel,
    input  logic [PAIR_WIDTH-1:0]   wr_pair_data,
    input  logic [3:0]              flag_we,
    input  logic [FLAG_WIDTH-1:0]   flag_in,
    output reg_bank_t               nxt
);

    reg_sel_t pair_hi_sel;
    reg_sel_t pair_lo_sel;
    logic     f_explicit;

    assign pair_hi_sel = pair_hi(wr_pair_sel);
    assign pair_lo_sel = pair_lo(wr_pair_sel);
    assign f_explicit  = (wr_en && (wr_sel == REG_F)) ||
                         (wr_pair_en && (wr_pair_sel == PAIR_AF));

    always_comb begin
        nxt = cur;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (wr_en && (wr_sel == reg_sel_t'(3'(i)))) begin
                nxt[i] = wr_data;
            end else if (wr_pair_en && (pair_hi_sel == reg_sel_t'(3'(i)))) begin
                nxt[i] = wr_pair_data[PAIR_WIDTH-1:DATA_WIDTH];
            end else if (wr_pair_en && (pair_lo_sel == reg_sel_t'(3'(i)))) begin
                nxt[i] = wr_pair_data[DATA_WIDTH-1:0];
            end
        end
        // Masked flag update only when neither write path claims F outright.
        if (!f_explicit) begin
            for (int k = 0; k < 4; k++) begin
                if (flag_we[k]) begin
                    nxt[REG_F][FLAG_C+k] = flag_in[FLAG_C+k];
                end
            end
        end
        nxt[REG_F][3:0] = 4'h0;
    end

endmodule

// File: rtl/reg_file.sv
// Game Boy CPU register file (B,C,D,E,H,L,F,A) with two 8-bit operand reads,
// one 16-bit pair read, and byte/pair/flag write-back. Optional same-cycle
// forwarding of write data to the read ports when REG_FILE_BYPASS_EN is defined.
module reg_file
    import gate_boy_pkg::*;
#(
    parameter logic [15:0] RESET_AF = 16'h01B0,
    parameter logic [15:0] RESET_BC = 16'h0013,
    parameter logic [15:0] RESET_DE = 16'h00D8,
    parameter logic [15:0] RESET_HL = 16'h014D
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);

    // Bank index order is A,F,L,H,E,D,C,B from the top element down.
    localparam reg_bank_t RESET_BANK = {
        RESET_AF[15:8], RESET_AF[7:4], 4'h0,
        RESET_HL[7:0],  RESET_HL[15:8],
        RESET_DE[7:0],  RESET_DE[15:8],
        RESET_BC[7:0],  RESET_BC[15:8]
    };

    reg_bank_t regs;
    reg_bank_t nxt;
    reg_bank_t view;

    reg_next u_reg_next (
        .cur          (regs),
        .wr_en        (bus.wr_en),
        .wr_sel       (bus.wr_sel),
        .wr_data      (bus.wr_data),
        .wr_pair_en   (bus.wr_pair_en),
        .wr_pair_sel  (bus.wr_pair_sel),
        .wr_pair_data (bus.wr_pair_data),
        .flag_we      (bus.flag_we),
        .flag_in      (bus.flag_in),
        .nxt          (nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= RESET_BANK;
        end else begin
            regs <= nxt;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // While reset is held the pending write is void, so show the reset state.
    assign view = rst ? regs : nxt;
`else
    assign view = regs;
`endif

    assign bus.rd_a_data    = view[bus.rd_a_sel];
    assign bus.rd_b_data    = view[bus.rd_b_sel];
    assign bus.rd_pair_data = {view[pair_hi(bus.rd_pair_sel)], view[pair_lo(bus.rd_pair_sel)]};
    assign bus.flags        = regs[REG_F];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_reg_file;
    import gate_boy_pkg::*;

    typedef logic [7:0][7:0] bank_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_if bus();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Post-boot values: B=00 C=13 D=00 E=D8 H=01 L=4D F=B0 A=01
    logic [7:0]  exp_rst  [8] = '{8'h00, 8'h13, 8'h00, 8'hD8, 8'h01, 8'h4D, 8'hB0, 8'h01};
    logic [15:0] exp_pair [4] = '{16'h0013, 16'h00D8, 16'h014D, 16'h01B0};

    bank_t m;

    function automatic int hi_idx(input int p);
        case (p)
            0: return 0;
            1: return 2;
            2: return 4;
            default: return 7;
        endcase
    endfunction

    function automatic int lo_idx(input int p);
        case (p)
            0: return 1;
            1: return 3;
            2: return 5;
            default: return 6;
        endcase
    endfunction

    // Apply writes lowest priority first so higher-priority writes overwrite.
    function automatic bank_t model_next(input bank_t cur);
        bank_t r;
        logic  f_wr;
        int    p;
        r = cur;
        p = int'(bus.wr_pair_sel);
        f_wr = (bus.wr_en && int'(bus.wr_sel) == 6) || (bus.wr_pair_en && p == 3);
        if (!f_wr) begin
            for (int k = 0; k < 4; k++)
                if (bus.flag_we[k]) r[6][4+k] = bus.flag_in[4+k];
        end
        if (bus.wr_pair_en) begin
            r[hi_idx(p)] = bus.wr_pair_data[15:8];
            r[lo_idx(p)] = bus.wr_pair_data[7:0];
        end
        if (bus.wr_en) r[int'(bus.wr_sel)] = bus.wr_data;
        r[6][3:0] = 4'h0;
        return r;
    endfunction

    function automatic bank_t reset_bank();
        bank_t r;
        for (int i = 0; i < 8; i++) r[i] = exp_rst[i];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= reset_bank();
        else     m <= model_next(m);
    end

    function automatic bank_t expected_view();
`ifdef REG_FILE_BYPASS_EN
        return rst ? m : model_next(m);
`else
        return m;
`endif
    endfunction

    task automatic drive_idle();
        bus.rd_a_sel     = REG_A;
        bus.rd_b_sel     = REG_B;
        bus.rd_pair_sel  = PAIR_BC;
        bus.wr_en        = 1'b0;
        bus.wr_sel       = REG_B;
        bus.wr_data      = 8'h00;
        bus.wr_pair_en   = 1'b0;
        bus.wr_pair_sel  = PAIR_BC;
        bus.wr_pair_data = 16'h0000;
        bus.flag_we      = 4'h0;
        bus.flag_in      = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        #12;
        for (int i = 0; i < 8; i++) begin
            bus.rd_a_sel = reg_sel_t'(3'(i));
            bus.rd_b_sel = reg_sel_t'(3'(7 - i));
            #1;
            n_vec++;
            if (bus.rd_a_data !== exp_rst[i]) begin
                n_err++;
                $display("FAIL reset_rd_a[%0d] got %h want %h", i, bus.rd_a_data, exp_rst[i]);
            end
            n_vec++;
            if (bus.rd_b_data !== exp_rst[7-i]) begin
                n_err++;
                $display("FAIL reset_rd_b[%0d] got %h want %h", 7 - i, bus.rd_b_data, exp_rst[7-i]);
            end
        end
        for (int p = 0; p < 4; p++) begin
            bus.rd_pair_sel = pair_sel_t'(2'(p));
            #1;
            n_vec++;
            if (bus.rd_pair_data !== exp_pair[p]) begin
                n_err++;
                $display("FAIL reset_pair[%0d] got %h want %h", p, bus.rd_pair_data, exp_pair[p]);
            end
        end
        n_vec++;
        if (bus.flags !== 8'hB0) begin
            n_err++;
            $display("FAIL reset_flags got %h want b0", bus.flags);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus.rd_pair_sel = PAIR_AF;
        #3;
        n_vec++;
        if (bus.rd_pair_data !== 16'h01B0) begin
            n_err++;
            $display("FAIL reset_release_af got %h want 01b0", bus.rd_pair_data);
        end
    endtask

    task automatic test_read_after_write();
        logic [7:0] same_cycle;
`ifdef REG_FILE_BYPASS_EN
        same_cycle = 8'h3C;
`else
        same_cycle = 8'h01;
`endif
        tick();
        bus.wr_en = 1'b1; bus.wr_sel = REG_A; bus.wr_data = 8'h3C;
        bus.rd_a_sel = REG_A;
        #3;
        n_vec++;
        if (bus.rd_a_data !== same_cycle) begin
            n_err++;
            $display("FAIL raw_same_cycle got %h want %h", bus.rd_a_data, same_cycle);
        end
        tick();
        bus.wr_en = 1'b0;
        #3;
        n_vec++;
        if (bus.rd_a_data !== 8'h3C) begin
            n_err++;
            $display("FAIL raw_next_cycle got %h want 3c", bus.rd_a_data);
        end
    endtask

    task automatic test_pair_af();
        tick();
        bus.wr_pair_en = 1'b1; bus.wr_pair_sel = PAIR_AF; bus.wr_pair_data = 16'h12FF;
        tick();
        drive_idle();
        bus.rd_a_sel = REG_A; bus.rd_b_sel = REG_F; bus.rd_pair_sel = PAIR_AF;
        #3;
        n_vec++;
        if (bus.rd_a_data !== 8'h12) begin
            n_err++; $display("FAIL pair_af_a got %h want 12", bus.rd_a_data);
        end
        n_vec++;
        if (bus.rd_b_data !== 8'hF0) begin
            n_err++; $display("FAIL pair_af_f got %h want f0", bus.rd_b_data);
        end
        n_vec++;
        if (bus.flags !== 8'hF0) begin
            n_err++; $display("FAIL pair_af_flags got %h want f0", bus.flags);
        end
        n_vec++;
        if (bus.rd_pair_data !== 16'h12F0) begin
            n_err++; $display("FAIL pair_af_read got %h want 12f0", bus.rd_pair_data);
        end
    endtask

    task automatic test_flag_mask();
        tick();
        bus.wr_en = 1'b1; bus.wr_sel = REG_F; bus.wr_data = 8'h00;
        tick();
        bus.wr_en = 1'b0;
        bus.flag_we = 4'b1010; bus.flag_in = 8'hF0;
        tick();
        bus.flag_we = 4'b0000;
        #3;
        n_vec++;
        if (bus.flags !== 8'hA0) begin
            n_err++; $display("FAIL flag_mask got %h want a0", bus.flags);
        end
    endtask

    task automatic test_priority();
        // 8-bit C beats pair low byte; pair B lands; flags apply since F untouched.
        tick();
        bus.wr_en = 1'b1; bus.wr_sel = REG_C; bus.wr_data = 8'hAA;
        bus.wr_pair_en = 1'b1; bus.wr_pair_sel = PAIR_BC; bus.wr_pair_data = 16'h1234;
        bus.flag_we = 4'b1111; bus.flag_in = 8'h5F;
        tick();
        drive_idle();
        bus.rd_a_sel = REG_B; bus.rd_b_sel = REG_C; bus.rd_pair_sel = PAIR_BC;
        #3;
        n_vec++;
        if (bus.rd_a_data !== 8'h12) begin
            n_err++; $display("FAIL prio_b got %h want 12", bus.rd_a_data);
        end
        n_vec++;
        if (bus.rd_b_data !== 8'hAA) begin
            n_err++; $display("FAIL prio_c got %h want aa", bus.rd_b_data);
        end
        n_vec++;
        if (bus.flags !== 8'h50) begin
            n_err++; $display("FAIL prio_flags got %h want 50", bus.flags);
        end
        // Explicit F write wins over flag_we; low nibble dropped.
        bus.wr_en = 1'b1; bus.wr_sel = REG_F; bus.wr_data = 8'hFF;
        bus.flag_we = 4'b1111; bus.flag_in = 8'h00;
        tick();
        drive_idle();
        #3;
        n_vec++;
        if (bus.flags !== 8'hF0) begin
            n_err++; $display("FAIL prio_f_explicit got %h want f0", bus.flags);
        end
        // 8-bit A beats pair AF high byte; F from the pair still lands.
        bus.wr_en = 1'b1; bus.wr_sel = REG_A; bus.wr_data = 8'h77;
        bus.wr_pair_en = 1'b1; bus.wr_pair_sel = PAIR_AF; bus.wr_pair_data = 16'h1234;
        tick();
        drive_idle();
        bus.rd_pair_sel = PAIR_AF;
        #3;
        n_vec++;
        if (bus.rd_pair_data !== 16'h7730) begin
            n_err++; $display("FAIL prio_af_split got %h want 7730", bus.rd_pair_data);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.wr_pair_en = 1'b1; bus.wr_pair_sel = PAIR_HL; bus.wr_pair_data = 16'hBEEF;
        bus.rd_pair_sel = PAIR_HL;
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.rd_pair_data !== 16'h014D) begin
            n_err++; $display("FAIL rst_mid_immediate got %h want 014d", bus.rd_pair_data);
        end
        tick();
        bus.wr_pair_en = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        #3;
        n_vec++;
        if (bus.rd_pair_data !== 16'h014D) begin
            n_err++; $display("FAIL rst_mid_write_lost got %h want 014d", bus.rd_pair_data);
        end
        bus.wr_pair_en = 1'b1; bus.wr_pair_data = 16'hBEEF;
        tick();
        bus.wr_pair_en = 1'b0;
        #3;
        n_vec++;
        if (bus.rd_pair_data !== 16'hBEEF) begin
            n_err++; $display("FAIL rst_mid_next_write got %h want beef", bus.rd_pair_data);
        end
    endtask

    task automatic test_random();
        bank_t     v;
        pair_sel_t ps;
        for (int n = 0; n < 400; n++) begin
            tick();
            bus.wr_en        = ($urandom_range(0, 2) == 0);
            bus.wr_sel       = reg_sel_t'(3'($urandom_range(0, 7)));
            bus.wr_data      = 8'($urandom);
            bus.wr_pair_en   = ($urandom_range(0, 2) == 0);
            bus.wr_pair_sel  = pair_sel_t'(2'($urandom_range(0, 3)));
            bus.wr_pair_data = 16'($urandom);
            bus.flag_we      = 4'($urandom);
            bus.flag_in      = 8'($urandom);
            bus.rd_a_sel     = reg_sel_t'(3'($urandom_range(0, 7)));
            bus.rd_b_sel     = reg_sel_t'(3'($urandom_range(0, 7)));
            bus.rd_pair_sel  = pair_sel_t'(2'($urandom_range(0, 3)));
            #3;
            v  = expected_view();
            ps = bus.rd_pair_sel;
            n_vec++;
            if (bus.rd_a_data !== v[int'(bus.rd_a_sel)]) begin
                n_err++;
                $display("FAIL rand_rd_a[%0d] got %h want %h", n, bus.rd_a_data, v[int'(bus.rd_a_sel)]);
            end
            n_vec++;
            if (bus.rd_b_data !== v[int'(bus.rd_b_sel)]) begin
                n_err++;
                $display("FAIL rand_rd_b[%0d] got %h want %h", n, bus.rd_b_data, v[int'(bus.rd_b_sel)]);
            end
            n_vec++;
            if (bus.rd_pair_data !== {v[hi_idx(int'(ps))], v[lo_idx(int'(ps))]}) begin
                n_err++;
                $display("FAIL rand_pair[%0d] got %h want %h", n, bus.rd_pair_data,
                         {v[hi_idx(int'(ps))], v[lo_idx(int'(ps))]});
            end
            n_vec++;
            if (bus.flags !== m[6]) begin
                n_err++;
                $display("FAIL rand_flags[%0d] got %h want %h", n, bus.flags, m[6]);
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_read_after_write();
        test_pair_af();
        test_flag_mask();
        test_priority();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
